// File: rtl/riscv_pkg.sv
// Shared types for the data-memory path: access sizes, port ids, request slot, arbiter states.
// No logic; widths follow RV_XLEN.
// Imported by the arbiter and its lane-alignment helper.
package riscv_pkg;

    localparam int RV_XLEN = 32;

    typedef enum logic [1:0] {
        MEM_B = 2'b00,
        MEM_H = 2'b01,
        MEM_W = 2'b10
    } mem_size_e;

    typedef enum logic {
        PORT_CPU = 1'b0,
        PORT_DBG = 1'b1
    } mem_port_e;

    typedef struct packed {
        logic               we;
        mem_size_e          size;
        logic [RV_XLEN-1:0] addr;
        logic [RV_XLEN-1:0] wdata;
    } mem_req_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } arb_state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane alignment: misalignment check, byte enables, store replication, load shift/mask.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the outputs are meaningful.
module dmem_lane_align
    import riscv_pkg::*;
#(
    parameter int XLEN = RV_XLEN
) (
    input  mem_size_e       size,
    input  logic [1:0]      offs,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] rword,
    output logic            err,
    output logic [3:0]      be,
    output logic [XLEN-1:0] wdata_rep,
    output logic [XLEN-1:0] rdata
);

    logic [XLEN-1:0] shifted;

    assign shifted = rword >> {offs, 3'b000};

    always_comb begin
        err       = 1'b0;
        be        = 4'b0000;
        wdata_rep = wdata;
        rdata     = '0;
        case (size)
            MEM_B: begin
                be        = 4'b0001 << offs;
                wdata_rep = XLEN'({4{wdata[7:0]}});
                rdata     = XLEN'(shifted[7:0]);
            end
            MEM_H: begin
                err       = offs[0];
                be        = offs[0] ? 4'b0000 : (4'b0011 << {offs[1], 1'b0});
                wdata_rep = XLEN'({2{wdata[15:0]}});
                rdata     = XLEN'(shifted[15:0]);
            end
            MEM_W: begin
                err   = |offs;
                be    = (|offs) ? 4'b0000 : 4'b1111;
                rdata = rword;
            end
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between the CPU and debug ports.
// Latency: grant to rvalid is MEM_LAT+1 cycles (1 cycle for misaligned/illegal accesses).
// Backpressure: requests are held until gnt; grants are only issued while IDLE.
module dmem_arbiter
    import riscv_pkg::*;
#(
    parameter int XLEN    = RV_XLEN,
    parameter int MEM_LAT = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [1:0]        cpu_size_i,
    input  logic [XLEN-1:0]   cpu_addr_i,
    input  logic [XLEN-1:0]   cpu_wdata_i,
    output logic              cpu_gnt_o,
    output logic              cpu_rvalid_o,
    output logic [XLEN-1:0]   cpu_rdata_o,
    output logic              cpu_err_o,
    input  logic              dbg_req_i,
    input  logic              dbg_we_i,
    input  logic [1:0]        dbg_size_i,
    input  logic [XLEN-1:0]   dbg_addr_i,
    input  logic [XLEN-1:0]   dbg_wdata_i,
    output logic              dbg_gnt_o,
    output logic              dbg_rvalid_o,
    output logic [XLEN-1:0]   dbg_rdata_o,
    output logic              dbg_err_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [3:0]        mem_be_o,
    output logic [XLEN-3:0]   mem_addr_o,
    output logic [XLEN-1:0]   mem_wdata_o,
    input  logic [XLEN-1:0]   mem_rdata_i
);

    arb_state_e      state_q, state_d;
    logic [1:0]      cnt_q, cnt_d;
    mem_port_e       last_q, last_d, owner_q, owner_d, win;
    mem_req_t        slot_q, slot_d, win_req, al_req;
    logic            err_q, err_d, grant;
    logic            al_err;
    logic [3:0]      al_be;
    logic [XLEN-1:0] al_wdata, al_rdata, resp_rdata;
    logic            slot_addr_unused;

    // Tie goes to the port that did not win last time.
    always_comb begin
        win = PORT_CPU;
        if (cpu_req_i && dbg_req_i) win = (last_q == PORT_DBG) ? PORT_CPU : PORT_DBG;
        else if (dbg_req_i)         win = PORT_DBG;
    end

    always_comb begin
        if (win == PORT_CPU)
            win_req = '{we: cpu_we_i, size: mem_size_e'(cpu_size_i), addr: cpu_addr_i, wdata: cpu_wdata_i};
        else
            win_req = '{we: dbg_we_i, size: mem_size_e'(dbg_size_i), addr: dbg_addr_i, wdata: dbg_wdata_i};
    end

    assign grant  = (state_q == IDLE) && !rst_i && (cpu_req_i || dbg_req_i);
    // One aligner serves the grant cycle (live winner) and the response cycle (registered slot).
    assign al_req = (state_q == IDLE) ? win_req : slot_q;

    dmem_lane_align #(.XLEN(XLEN)) u_align (
        .size      (al_req.size),
        .offs      (al_req.addr[1:0]),
        .wdata     (al_req.wdata),
        .rword     (slot_q.wdata),
        .err       (al_err),
        .be        (al_be),
        .wdata_rep (al_wdata),
        .rdata     (al_rdata)
    );

    assign resp_rdata       = (slot_q.we || err_q) ? '0 : al_rdata;
    assign slot_addr_unused = ^slot_q.addr[XLEN-1:2];

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_d       = last_q;
        owner_d      = owner_q;
        slot_d       = slot_q;
        err_d        = err_q;
        cpu_gnt_o    = 1'b0;
        dbg_gnt_o    = 1'b0;
        cpu_rvalid_o = 1'b0;
        dbg_rvalid_o = 1'b0;
        cpu_rdata_o  = '0;
        dbg_rdata_o  = '0;
        cpu_err_o    = 1'b0;
        dbg_err_o    = 1'b0;
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        mem_be_o     = 4'b0000;
        mem_addr_o   = '0;
        mem_wdata_o  = '0;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    cpu_gnt_o = (win == PORT_CPU);
                    dbg_gnt_o = (win == PORT_DBG);
                    slot_d    = win_req;
                    owner_d   = win;
                    last_d    = win;
                    err_d     = al_err;
                    if (al_err) begin
                        state_d = RESP;
                    end else begin
                        mem_req_o   = 1'b1;
                        mem_we_o    = win_req.we;
                        mem_be_o    = al_be;
                        mem_addr_o  = win_req.addr[XLEN-1:2];
                        mem_wdata_o = al_wdata;
                        cnt_d       = 2'(MEM_LAT - 1);
                        state_d     = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 2'd0) begin
                    slot_d.wdata = mem_rdata_i;
                    state_d      = RESP;
                end else begin
                    cnt_d = 2'(cnt_q - 2'd1);
                end
            end
            RESP: begin
                state_d = IDLE;
                if (!rst_i) begin
                    if (owner_q == PORT_CPU) begin
                        cpu_rvalid_o = 1'b1;
                        cpu_rdata_o  = resp_rdata;
                        cpu_err_o    = err_q;
                    end else begin
                        dbg_rvalid_o = 1'b1;
                        dbg_rdata_o  = resp_rdata;
                        dbg_err_o    = err_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            last_q  <= PORT_DBG;
            owner_q <= PORT_CPU;
            slot_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            slot_q  <= slot_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: two instances (MEM_LAT 1 and 3), a byte-addressed shadow memory and
// a transaction-timing reference model derived from the access rules.
module tb_dmem_arbiter;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       rst = 2'b11;
    logic [1:0]       cpu_req = '0, cpu_we = '0, dbg_req = '0, dbg_we = '0;
    logic [1:0][1:0]  cpu_size = '0, dbg_size = '0;
    logic [1:0][31:0] cpu_addr = '0, cpu_wdata = '0, dbg_addr = '0, dbg_wdata = '0;
    logic [1:0]       cpu_gnt, cpu_rvalid, cpu_err, dbg_gnt, dbg_rvalid, dbg_err, mem_req, mem_we;
    logic [1:0][31:0] cpu_rdata, dbg_rdata, mem_wdata, mem_rdata;
    logic [1:0][3:0]  mem_be;
    logic [1:0][29:0] mem_addr;

    dmem_arbiter #(.XLEN(32), .MEM_LAT(1)) u_dut0 (
        .clk_i(clk), .rst_i(rst[0]),
        .cpu_req_i(cpu_req[0]), .cpu_we_i(cpu_we[0]), .cpu_size_i(cpu_size[0]),
        .cpu_addr_i(cpu_addr[0]), .cpu_wdata_i(cpu_wdata[0]), .cpu_gnt_o(cpu_gnt[0]),
        .cpu_rvalid_o(cpu_rvalid[0]), .cpu_rdata_o(cpu_rdata[0]), .cpu_err_o(cpu_err[0]),
        .dbg_req_i(dbg_req[0]), .dbg_we_i(dbg_we[0]), .dbg_size_i(dbg_size[0]),
        .dbg_addr_i(dbg_addr[0]), .dbg_wdata_i(dbg_wdata[0]), .dbg_gnt_o(dbg_gnt[0]),
        .dbg_rvalid_o(dbg_rvalid[0]), .dbg_rdata_o(dbg_rdata[0]), .dbg_err_o(dbg_err[0]),
        .mem_req_o(mem_req[0]), .mem_we_o(mem_we[0]), .mem_be_o(mem_be[0]),
        .mem_addr_o(mem_addr[0]), .mem_wdata_o(mem_wdata[0]), .mem_rdata_i(mem_rdata[0])
    );

    dmem_arbiter #(.XLEN(32), .MEM_LAT(3)) u_dut1 (
        .clk_i(clk), .rst_i(rst[1]),
        .cpu_req_i(cpu_req[1]), .cpu_we_i(cpu_we[1]), .cpu_size_i(cpu_size[1]),
        .cpu_addr_i(cpu_addr[1]), .cpu_wdata_i(cpu_wdata[1]), .cpu_gnt_o(cpu_gnt[1]),
        .cpu_rvalid_o(cpu_rvalid[1]), .cpu_rdata_o(cpu_rdata[1]), .cpu_err_o(cpu_err[1]),
        .dbg_req_i(dbg_req[1]), .dbg_we_i(dbg_we[1]), .dbg_size_i(dbg_size[1]),
        .dbg_addr_i(dbg_addr[1]), .dbg_wdata_i(dbg_wdata[1]), .dbg_gnt_o(dbg_gnt[1]),
        .dbg_rvalid_o(dbg_rvalid[1]), .dbg_rdata_o(dbg_rdata[1]), .dbg_err_o(dbg_err[1]),
        .mem_req_o(mem_req[1]), .mem_we_o(mem_we[1]), .mem_be_o(mem_be[1]),
        .mem_addr_o(mem_addr[1]), .mem_wdata_o(mem_wdata[1]), .mem_rdata_i(mem_rdata[1])
    );

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic logic [7:0] init_byte(input int a);
        return 8'(a * 7 + 1);
    endfunction

    // Memory: applies byte-enabled writes, returns read data exactly MEM_LAT cycles after mem_req.
    logic [31:0] mem_w [2][16];
    int          rem [2];
    logic [31:0] rword [2];

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst[k]) begin
                for (int w = 0; w < 16; w++)
                    for (int b = 0; b < 4; b++)
                        mem_w[k][w][8*b +: 8] <= init_byte(4 * w + b);
                rem[k] <= 0;
            end else begin
                if (mem_req[k] && mem_we[k])
                    for (int b = 0; b < 4; b++)
                        if (mem_be[k][b])
                            mem_w[k][mem_addr[k][3:0]][8*b +: 8] <= mem_wdata[k][8*b +: 8];
                if (mem_req[k] && !mem_we[k]) begin
                    rem[k]   <= lat_of(k);
                    rword[k] <= mem_w[k][mem_addr[k][3:0]];
                end else if (rem[k] != 0) begin
                    rem[k] <= rem[k] - 1;
                end
            end
        end
    end

    assign mem_rdata[0] = (rem[0] == 1) ? rword[0] : 32'hA5C3_0F96;
    assign mem_rdata[1] = (rem[1] == 1) ? rword[1] : 32'hA5C3_0F96;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Reference model: requester queues, shadow byte memory and access timing.
    txn_t        qc[$], qd[$];
    bit          rnd_on = 1'b0;
    int          cyc = 0, next_free = 0, resp_cyc = -1, resp_port = 0, last_port = 1;
    logic        resp_err = 1'b0;
    logic [31:0] resp_rdata = '0;
    logic [7:0]  sh [64];

    function automatic int nbytes(input logic [1:0] s);
        return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    endfunction

    task automatic step(input int k, input bit rst_v);
        txn_t        t;
        int          win, nb, lane, idx;
        bit          rc, rd, lg, exp_c, exp_d;
        logic [3:0]  be;
        logic [31:0] rdv;
        @(negedge clk);
        rst[k] = rst_v;
        rc = (qc.size() != 0) && (!rnd_on || $urandom_range(0, 3) != 0);
        rd = (qd.size() != 0) && (!rnd_on || $urandom_range(0, 3) != 0);
        cpu_req[k] = rc;
        dbg_req[k] = rd;
        if (qc.size() != 0) begin
            cpu_we[k] = qc[0].we; cpu_size[k] = qc[0].size;
            cpu_addr[k] = qc[0].addr; cpu_wdata[k] = qc[0].wdata;
        end
        if (qd.size() != 0) begin
            dbg_we[k] = qd[0].we; dbg_size[k] = qd[0].size;
            dbg_addr[k] = qd[0].addr; dbg_wdata[k] = qd[0].wdata;
        end
        #1;
        win = -1;
        if (!rst_v && cyc >= next_free && (rc || rd))
            win = (rc && rd) ? ((last_port == 1) ? 0 : 1) : (rc ? 0 : 1);
        check_val("cpu_gnt", 32'(cpu_gnt[k]), 32'(win == 0));
        check_val("dbg_gnt", 32'(dbg_gnt[k]), 32'(win == 1));
        if (win >= 0) begin
            t   = (win == 0) ? qc.pop_front() : qd.pop_front();
            nb  = nbytes(t.size);
            lg  = (t.size != 2'd3) && ((int'(t.addr[1:0]) % nb) == 0);
            rdv = '0;
            check_val("mem_req", 32'(mem_req[k]), 32'(lg));
            if (lg) begin
                be = 4'b0000;
                check_val("mem_we", 32'(mem_we[k]), 32'(t.we));
                check_val("mem_addr", 32'(mem_addr[k]), t.addr >> 2);
                for (int j = 0; j < nb; j++) begin
                    lane = int'(t.addr[1:0]) + j;
                    idx  = int'((t.addr + 32'(j)) & 32'd63);
                    be[lane] = 1'b1;
                    if (t.we) begin
                        check_val("mem_wdata_lane", 32'(mem_wdata[k][8*lane +: 8]), 32'(t.wdata[8*j +: 8]));
                        sh[idx] = t.wdata[8*j +: 8];
                    end else begin
                        rdv = rdv | (32'(sh[idx]) << (8 * j));
                    end
                end
                check_val("mem_be", 32'(mem_be[k]), 32'(be));
            end
            resp_cyc   = cyc + (lg ? lat_of(k) + 1 : 1);
            next_free  = resp_cyc + 1;
            last_port  = win;
            resp_port  = win;
            resp_err   = !lg;
            resp_rdata = (lg && !t.we) ? rdv : 32'h0;
        end else begin
            check_val("mem_req_idle", 32'(mem_req[k]), 32'h0);
        end
        exp_c = !rst_v && (cyc == resp_cyc) && (resp_port == 0);
        exp_d = !rst_v && (cyc == resp_cyc) && (resp_port == 1);
        check_val("cpu_rvalid", 32'(cpu_rvalid[k]), 32'(exp_c));
        check_val("dbg_rvalid", 32'(dbg_rvalid[k]), 32'(exp_d));
        if (exp_c) begin
            check_val("cpu_err", 32'(cpu_err[k]), 32'(resp_err));
            check_val("cpu_rdata", cpu_rdata[k], resp_rdata);
        end
        if (exp_d) begin
            check_val("dbg_err", 32'(dbg_err[k]), 32'(resp_err));
            check_val("dbg_rdata", dbg_rdata[k], resp_rdata);
        end
        if (rst_v) begin
            next_free = cyc + 1;
            resp_cyc  = -1;
            last_port = 1;
            for (int a = 0; a < 64; a++) sh[a] = init_byte(a);
        end
        cyc++;
    endtask

    task automatic drain(input int k, input int cap);
        int n = 0;
        while ((qc.size() != 0 || qd.size() != 0 || cyc < next_free) && n < cap) begin
            step(k, 1'b0);
            n++;
        end
        check_val("drain_left", 32'(qc.size() + qd.size()), 32'h0);
    endtask

    function automatic txn_t rand_txn();
        txn_t t;
        int   r;
        r       = $urandom_range(0, 7);
        t.size  = (r < 7) ? 2'(r % 3) : 2'd3;
        t.addr  = 32'($urandom_range(0, 63));
        if (t.size != 2'd3 && $urandom_range(0, 3) != 0)
            t.addr = t.addr & ~32'(nbytes(t.size) - 1);
        t.we    = 1'($urandom_range(0, 1));
        t.wdata = $urandom;
        return t;
    endfunction

    initial begin
        // Instance 0, MEM_LAT=1: reset, tie from reset with directed accesses, then errors.
        rnd_on = 1'b0;
        repeat (2) step(0, 1'b1);
        qc.push_back('{1'b1, 2'd2, 32'h10, 32'hDEAD_BEEF});
        qc.push_back('{1'b0, 2'd0, 32'h13, 32'h0});
        qc.push_back('{1'b0, 2'd2, 32'h10, 32'h0});
        qd.push_back('{1'b1, 2'd1, 32'h06, 32'h0000_1234});
        qd.push_back('{1'b0, 2'd1, 32'h06, 32'h0});
        qd.push_back('{1'b0, 2'd0, 32'h07, 32'h0});
        drain(0, 60);
        qc.push_back('{1'b0, 2'd2, 32'h02, 32'h0});
        qc.push_back('{1'b0, 2'd3, 32'h08, 32'h0});
        qd.push_back('{1'b1, 2'd1, 32'h01, 32'hFFFF_FFFF});
        qd.push_back('{1'b0, 2'd2, 32'h00, 32'h0});
        drain(0, 40);
        rnd_on = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 1) != 0) qc.push_back(rand_txn());
            else                           qd.push_back(rand_txn());
        end
        drain(0, 3000);

        // Instance 1, MEM_LAT=3: random traffic, then reset while an access sits in WAIT.
        repeat (2) step(1, 1'b1);
        for (int i = 0; i < 120; i++) begin
            qc.push_back(rand_txn());
            qd.push_back(rand_txn());
        end
        drain(1, 4000);
        rnd_on = 1'b0;
        qc.push_back('{1'b0, 2'd2, 32'h20, 32'h0});
        step(1, 1'b0);
        step(1, 1'b1);
        repeat (5) step(1, 1'b0);
        qc.push_back('{1'b0, 2'd2, 32'h24, 32'h0});
        qd.push_back('{1'b0, 2'd0, 32'h25, 32'h0});
        drain(1, 40);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: the CPU memory stage (port 0, "cpu") and the debug/program-loader port (port 1, "dbg").
- Arbitrates between the two ports with round-robin priority and sequences each access over a fixed memory latency.
- Generates byte enables and lane-aligned write data.
- Returns right-justified read data and flags misaligned accesses without touching memory.

Parameters:
- XLEN, 32, data and address width.
- MEM_LAT, 1, memory read latency in cycles from mem_req_o to valid mem_rdata_i; legal range 1..4.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- cpu_req_i  in  1  CPU access request; held with its fields stable until cpu_gnt_o
- cpu_we_i  in  1  1 = store, 0 = load
- cpu_size_i  in  2  mem_size_e: 00 byte, 01 half, 10 word, 11 illegal
- cpu_addr_i  in  XLEN  byte address
- cpu_wdata_i  in  XLEN  store data, right-justified
- cpu_gnt_o  out  1  request accepted this cycle
- cpu_rvalid_o  out  1  one-cycle completion pulse, for loads and stores
- cpu_rdata_o  out  XLEN  load data, right-justified, zero-extended
- cpu_err_o  out  1  misaligned or illegal size; qualified by cpu_rvalid_o
- dbg_req_i, dbg_we_i, dbg_size_i, dbg_addr_i, dbg_wdata_i, dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o, dbg_err_o: same widths and meanings as the cpu_ set, for port 1
- mem_req_o  out  1  memory access strobe, one cycle
- mem_we_o  out  1  memory write
- mem_be_o  out  4  byte enables
- mem_addr_o  out  XLEN-2  word address, equal to addr[XLEN-1:2]
- mem_wdata_o  out  XLEN  lane-replicated store data
- mem_rdata_i  in  XLEN  raw memory word

Behaviour:
- State machine, states IDLE, WAIT, RESP; reset state IDLE.
- IDLE:
  - If any request is pending, pick a winner. If only one port requests, it wins. If both request, the port not granted last wins; last_gnt resets to dbg, so the cpu wins the first tie.
  - The winner's gnt_o is asserted combinationally in the same cycle.
  - The winner's we, size, addr and wdata are registered into an in-flight slot, and last_gnt is updated.
  - Legal access: mem_req_o=1 in the grant cycle, driven from the un-registered winner fields; next state WAIT, with a latency counter loaded to MEM_LAT-1.
  - Misaligned or illegal access (half with addr[0]=1, word with addr[1:0]!=0, size 11): mem_req_o=0; next state RESP with err=1.
- WAIT: the counter decrements each cycle. At 0, capture mem_rdata_i into the in-flight slot and go to RESP. With MEM_LAT=1, WAIT lasts exactly one cycle.
- RESP:
  - The owner's rvalid_o pulses for one cycle; the other port's rvalid_o stays 0. Next state IDLE.
  - The owner's rdata_o carries the load data; err_o as computed at grant.
- Timing: gnt to rvalid is MEM_LAT+1 cycles for legal accesses and 1 cycle for erroneous ones. Sustained throughput is one access per MEM_LAT+2 cycles. No grant is given outside IDLE.
- Byte enables:
  - byte: 4'b0001 << addr[1:0]
  - half: 4'b0011 << {addr[1],1'b0}
  - word: 4'b1111
  - erroneous access: 0
- mem_wdata_o: byte replicated to all four lanes, half replicated to both halves, word passed through.
- rdata_o = (captured word >> 8*addr[1:0]), masked to the access size, zero-extended; the requester performs sign extension.
- For stores and erroneous accesses, rdata_o = 0.
- Reset values, all outputs: 0. Also gnt=0, rvalid=0, err=0, mem_req_o=0, state IDLE, counter 0, last_gnt=dbg.
- rst_i mid-access: return to IDLE next cycle; the in-flight access is dropped with no rvalid. A write already strobed is not undone.
- Simultaneous events: a request arriving in the RESP cycle waits until IDLE. A deasserted request before grant is legal, and no access occurs.

Decomposition:
- riscv_pkg gets:
  - mem_size_e (MEM_B, MEM_H, MEM_W)
  - mem_req_t struct {we, size, addr, wdata}
  - mem_port_e (PORT_CPU, PORT_DBG)
- One combinational sub-module, dmem_lane_align, owns misalignment detection, mem_be_o generation, wdata replication and rdata shift/mask.
- The arbiter FSM, counter and round-robin state stay in dmem_arbiter.

Test Plan:
- CPU word store addr 0x10, data 0xDEADBEEF, MEM_LAT=1 -> gnt same cycle; mem_addr_o=0x4, mem_be_o=4'hF; cpu_rvalid_o two cycles later, err=0.
- CPU byte load addr 0x13, memory word 0xDEADBEEF -> mem_be_o=4'b1000; cpu_rdata_o=0x000000DE at rvalid.
- Both ports request from reset -> cpu granted first, dbg granted in the next IDLE; repeated ties alternate cpu, dbg, cpu.
- dbg half store addr 0x6, data 0x1234 -> mem_be_o=4'b1100, mem_wdata_o=0x12341234.
- CPU word load addr 0x2 -> no mem_req_o; rvalid next cycle with err=1, rdata=0. Size 11 gives the same response.
- MEM_LAT=3 CPU load with rst_i asserted in WAIT -> state IDLE, no rvalid, and a fresh request after reset is granted normally.
